// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bundle: the hazard/EX/imem side drives requests, the sequencer drives PC and IF/ID controls.
// Latency: none, this is only wiring.
// Backpressure: imem_ready and hazard_stall are the stall sources; there are no credits.
//   master : redirect_valid/redirect_target, hazard_stall, halt, imem_ready out; controls in
//   slave  : the reverse, used by fetch_sequencer
interface fetch_sequencer_if #(
   parameter int ADDR_WIDTH = 20,
   parameter int CNT_WIDTH  = 8
);
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_target;
   logic                  hazard_stall;
   logic                  halt;
   logic                  imem_ready;
   logic                  imem_req;
   logic                  pc_stall;
   logic                  pc_load;
   logic [ADDR_WIDTH-1:0] pc_target;
   logic                  fetch_valid;
   logic                  flush_if;
   logic                  flush_id;
   logic [1:0]            state_dbg;
   logic [CNT_WIDTH-1:0]  redirect_count;

   modport master (
      output redirect_valid, redirect_target, hazard_stall, halt, imem_ready,
      input  imem_req, pc_stall, pc_load, pc_target, fetch_valid, flush_if, flush_id,
             state_dbg, redirect_count
   );

   modport slave (
      input  redirect_valid, redirect_target, hazard_stall, halt, imem_ready,
      output imem_req, pc_stall, pc_load, pc_target, fetch_valid, flush_if, flush_id,
             state_dbg, redirect_count
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: arbitrates redirect > halt > load-use stall > imem wait.
// Latency: Mealy outputs, so a redirect loads the PC on the same edge it is presented.
// Backpressure: imem_ready low parks the FSM in WAIT; hazard_stall holds PC and IF/ID.
//   clock_i   : rising-edge clock
//   reset_n_i : asynchronous active-low reset
//   bus       : slave side of fetch_sequencer_if (redirect/hazard/halt/imem in, PC/IF-ID controls out)
module fetch_sequencer #(
   parameter int ADDR_WIDTH = 20,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clock_i,
   input  logic                  reset_n_i,
   fetch_sequencer_if.slave      bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      WAIT   = 2'd2,
      HALTED = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [ADDR_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic                  req_c, stall_c, load_c, fv_c, fif_c, fid_c;
   logic [ADDR_WIDTH-1:0] tgt_c;

   // State register
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= IDLE;
         pend_vld_q <= 1'b0;
         pend_tgt_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pend_vld_q <= pend_vld_d;
         pend_tgt_q <= pend_tgt_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      pend_vld_d = pend_vld_q;
      pend_tgt_d = pend_tgt_q;
      case (state_q)
         IDLE:   state_d = FETCH;
         FETCH: begin
            if (bus.redirect_valid)    state_d = FETCH;
            else if (bus.halt)         state_d = HALTED;
            else if (bus.hazard_stall) state_d = FETCH;
            else if (!bus.imem_ready)  state_d = WAIT;
         end
         WAIT: begin
            if (bus.imem_ready) begin
               if (bus.redirect_valid || pend_vld_q) begin
                  state_d    = FETCH;
                  pend_vld_d = 1'b0;
               end else if (!bus.hazard_stall) begin
                  state_d = FETCH;
               end
            end else if (bus.redirect_valid) begin
               // Youngest EX redirect wins while memory is still busy
               pend_vld_d = 1'b1;
               pend_tgt_d = bus.redirect_target;
            end
         end
         HALTED: if (bus.redirect_valid) state_d = FETCH;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      req_c   = 1'b0;
      stall_c = 1'b0;
      load_c  = 1'b0;
      tgt_c   = '0;
      fv_c    = 1'b0;
      fif_c   = 1'b0;
      fid_c   = 1'b0;
      case (state_q)
         IDLE: stall_c = 1'b1;
         FETCH: begin
            req_c = 1'b1;
            if (bus.redirect_valid) begin
               load_c = 1'b1;
               tgt_c  = bus.redirect_target;
               fif_c  = 1'b1;
               fid_c  = 1'b1;
            end else if (bus.halt || bus.hazard_stall || !bus.imem_ready) begin
               stall_c = 1'b1;
            end else begin
               fv_c = 1'b1;
            end
         end
         WAIT: begin
            req_c = 1'b1;
            if (bus.imem_ready) begin
               if (bus.redirect_valid || pend_vld_q) begin
                  // The word arriving now is wrong-path, so it is dropped
                  load_c = 1'b1;
                  tgt_c  = bus.redirect_valid ? bus.redirect_target : pend_tgt_q;
                  fif_c  = 1'b1;
               end else if (bus.hazard_stall) begin
                  stall_c = 1'b1;
               end else begin
                  fv_c = 1'b1;
               end
            end else begin
               stall_c = 1'b1;
               if (bus.redirect_valid) begin
                  fif_c = 1'b1;
                  fid_c = 1'b1;
               end
            end
         end
         HALTED: begin
            if (bus.redirect_valid) begin
               load_c = 1'b1;
               tgt_c  = bus.redirect_target;
               fif_c  = 1'b1;
               fid_c  = 1'b1;
            end else begin
               stall_c = 1'b1;
            end
         end
         default: stall_c = 1'b1;
      endcase
   end

   // Saturating pc_load counter
   assign cnt_d = (load_c && (cnt_q != '1)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

   assign bus.imem_req       = req_c;
   assign bus.pc_stall       = stall_c;
   assign bus.pc_load        = load_c;
   assign bus.pc_target      = tgt_c;
   assign bus.fetch_valid    = fv_c;
   assign bus.flush_if       = fif_c;
   assign bus.flush_id       = fid_c;
   assign bus.state_dbg      = state_q;
   assign bus.redirect_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
   localparam int AW  = 20;
   localparam int CW  = 8;
   localparam int SAT = (1 << CW) - 1;

   localparam int M_IDLE   = 0;
   localparam int M_FETCH  = 1;
   localparam int M_WAIT   = 2;
   localparam int M_HALTED = 3;

   typedef struct packed {
      logic          req;
      logic          stall;
      logic          load;
      logic [AW-1:0] tgt;
      logic          fv;
      logic          fif;
      logic          fid;
      logic [1:0]    st;
      logic [CW-1:0] cnt;
   } exp_t;

   logic clock = 1'b0;
   logic rst_n = 1'b0;

   fetch_sequencer_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   fetch_sequencer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clock_i   (clock),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   always #5 clock = ~clock;

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;

   // Reference model: abstract fetch mode, pending redirect, and total load count
   int          m_mode  = M_IDLE;
   bit          m_pend  = 1'b0;
   logic [AW-1:0] m_ptgt = '0;
   int          m_loads = 0;

   task automatic apply(input bit rv, input logic [AW-1:0] rt, input bit hz,
                        input bit ht, input bit rdy, input bit rst);
      exp_t e;
      int   nxt;
      @(posedge clock);
      #1;
      rst_n               = rst;
      bus.redirect_valid  = rv;
      bus.redirect_target = rt;
      bus.hazard_stall    = hz;
      bus.halt            = ht;
      bus.imem_ready      = rdy;
      cyc++;

      if (!rst) begin
         m_mode  = M_IDLE;
         m_pend  = 1'b0;
         m_ptgt  = '0;
         m_loads = 0;
      end
      e     = '0;
      e.st  = 2'(m_mode);
      e.cnt = CW'((m_loads > SAT) ? SAT : m_loads);
      nxt   = m_mode;

      if (!rst) begin
         e.stall = 1'b1;
      end else if (m_mode == M_IDLE) begin
         e.stall = 1'b1;
         nxt     = M_FETCH;
      end else if (m_mode == M_FETCH) begin
         e.req = 1'b1;
         if (rv) begin
            e.load = 1'b1; e.tgt = rt; e.fif = 1'b1; e.fid = 1'b1;
         end else if (ht) begin
            e.stall = 1'b1; nxt = M_HALTED;
         end else if (hz) begin
            e.stall = 1'b1;
         end else if (!rdy) begin
            e.stall = 1'b1; nxt = M_WAIT;
         end else begin
            e.fv = 1'b1;
         end
      end else if (m_mode == M_WAIT) begin
         e.req = 1'b1;
         if (!rdy) begin
            e.stall = 1'b1;
            if (rv) begin
               m_pend = 1'b1; m_ptgt = rt; e.fif = 1'b1; e.fid = 1'b1;
            end
         end else if (rv || m_pend) begin
            e.load = 1'b1;
            e.tgt  = rv ? rt : m_ptgt;
            e.fif  = 1'b1;
            m_pend = 1'b0;
            nxt    = M_FETCH;
         end else if (hz) begin
            e.stall = 1'b1;
         end else begin
            e.fv = 1'b1; nxt = M_FETCH;
         end
      end else begin
         if (rv) begin
            e.load = 1'b1; e.tgt = rt; e.fif = 1'b1; e.fid = 1'b1; nxt = M_FETCH;
         end else begin
            e.stall = 1'b1;
         end
      end

      if (e.load) m_loads++;
      m_mode = nxt;
      sb_q.push_back(e);
   endtask

   // Monitor: every cycle the DUT presents its controls, compare against the oldest expectation
   initial begin
      exp_t e, a;
      forever begin
         @(negedge clock);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a.req   = bus.imem_req;
            a.stall = bus.pc_stall;
            a.load  = bus.pc_load;
            a.tgt   = bus.pc_target;
            a.fv    = bus.fetch_valid;
            a.fif   = bus.flush_if;
            a.fid   = bus.flush_id;
            a.st    = bus.state_dbg;
            a.cnt   = bus.redirect_count;
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL ctrl cyc=%0d got req=%b stall=%b load=%b tgt=%h fv=%b fif=%b fid=%b st=%0d cnt=%0d | want req=%b stall=%b load=%b tgt=%h fv=%b fif=%b fid=%b st=%0d cnt=%0d",
                        cyc, a.req, a.stall, a.load, a.tgt, a.fv, a.fif, a.fid, a.st, a.cnt,
                        e.req, e.stall, e.load, e.tgt, e.fv, e.fif, e.fid, e.st, e.cnt);
            end
         end
      end
   end

   initial begin
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = '0;
      bus.hazard_stall    = 1'b0;
      bus.halt            = 1'b0;
      bus.imem_ready      = 1'b0;

      // Reset held, then release with a clean memory
      repeat (2) apply(0, '0, 0, 0, 1, 0);
      repeat (5) apply(0, '0, 0, 0, 1, 1);

      // Redirect in FETCH, then normal fetch
      apply(1, 20'h00F1F, 0, 0, 1, 1);
      repeat (2) apply(0, '0, 0, 0, 1, 1);

      // Three memory wait cycles with a redirect during the second wait
      apply(0, '0, 0, 0, 0, 1);
      apply(0, '0, 0, 0, 0, 1);
      apply(1, 20'h00100, 0, 0, 0, 1);
      apply(0, '0, 0, 0, 1, 1);
      repeat (2) apply(0, '0, 0, 0, 1, 1);

      // Halt and hazard together, sit halted, then a redirect cancels the halt
      apply(0, '0, 1, 1, 1, 1);
      repeat (3) apply(0, '0, 1, 1, 1, 1);
      apply(1, 20'h00040, 0, 0, 1, 1);
      repeat (2) apply(0, '0, 0, 0, 1, 1);

      // Two-cycle load-use stall, then a redirect during a stall
      repeat (2) apply(0, '0, 1, 0, 1, 1);
      apply(0, '0, 0, 0, 1, 1);
      apply(1, 20'h0ABCD, 1, 0, 1, 1);
      apply(0, '0, 0, 0, 1, 1);

      // Counter saturation
      for (int i = 0; i < 300; i++) apply(1, AW'(i), 0, 0, 1, 1);
      apply(0, '0, 0, 0, 1, 1);

      // Reset while WAIT holds a pending redirect
      apply(0, '0, 0, 0, 0, 1);
      apply(1, 20'h12345, 0, 0, 0, 1);
      apply(0, '0, 0, 0, 0, 0);
      apply(0, '0, 0, 0, 1, 0);
      repeat (4) apply(0, '0, 0, 0, 1, 1);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         apply($urandom_range(0, 99) < 20, AW'($urandom), $urandom_range(0, 99) < 20,
               $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 65,
               $urandom_range(0, 199) != 0);
      end
      repeat (3) apply(0, '0, 0, 0, 1, 1);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
         @(negedge clock);
         #1;
      end
      if (sb_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM that sequences the instruction-fetch stage.
- Drives the PC register's stall/load/target inputs and the IF/ID pipeline-register valid/flush controls.
- Arbitrates between branch/jump redirects from EX, load-use stalls from ID, halt from ID and instruction-memory wait states.
- Sits between the PC register, instruction memory and the hazard logic.

Parameters:
ADDR_WIDTH, 20, width of PC and redirect target
CNT_WIDTH, 8, width of the saturating redirect counter

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
redirect_valid  input  1  taken branch/jump resolved in EX this cycle
redirect_target  input  ADDR_WIDTH  target address for redirect_valid
hazard_stall  input  1  load-use stall from ID; hold PC and IF/ID
halt  input  1  halt instruction decoded in ID
imem_ready  input  1  instruction memory delivers data for the current PC this cycle
imem_req  output  1  fetch request to instruction memory
pc_stall  output  1  PC register holds
pc_load  output  1  PC register loads pc_target
pc_target  output  ADDR_WIDTH  load value for PC
fetch_valid  output  1  IF/ID captures a valid instruction this cycle
flush_if  output  1  invalidate IF/ID contents
flush_id  output  1  invalidate ID/EX contents
state_dbg  output  2  current state: IDLE=0, FETCH=1, WAIT=2, HALTED=3
redirect_count  output  CNT_WIDTH  number of pc_load pulses, saturating

Behaviour:
- Registered: state, pend_valid, pend_target, redirect_count. All other outputs are combinational from state, pend and inputs (Mealy), so that a redirect loads the PC on the same edge.
- Reset (reset=0, asynchronous): state=IDLE, pend_valid=0, pend_target=0, redirect_count=0.
- Defaults when not stated otherwise: imem_req=0, pc_stall=0, pc_load=0, pc_target=0, fetch_valid=0, flush_if=0, flush_id=0.
- IDLE:
  - pc_stall=1.
  - Always moves to FETCH on the next edge; inputs are ignored. This gives one dead cycle after reset release.
- FETCH: imem_req=1. Priority is redirect > halt > hazard_stall > !imem_ready.
  - redirect_valid: pc_load=1, pc_target=redirect_target, flush_if=1, flush_id=1. Stay in FETCH.
  - halt: pc_stall=1. Go to HALTED.
  - hazard_stall: pc_stall=1, fetch_valid=0 (IF/ID holds). Stay in FETCH.
  - !imem_ready: pc_stall=1. Go to WAIT.
  - Otherwise: fetch_valid=1, PC increments (pc_stall=0, pc_load=0). Stay in FETCH.
- WAIT: imem_req=1, pc_stall=1 unless loading.
  - redirect_valid without imem_ready: latch pend_valid=1 and pend_target=redirect_target; assert flush_id=1 and flush_if=1. A later redirect overwrites pend_target (youngest EX redirect wins).
  - imem_ready with a redirect pending (pend_valid, or redirect_valid this cycle; this cycle's target has priority):
    - pc_load=1, pc_target = that target, fetch_valid=0 (wrong-path word discarded), flush_if=1.
    - Clear pend_valid, go to FETCH.
  - imem_ready, no pending redirect, hazard_stall=1: remain in WAIT and re-request the same PC.
  - imem_ready, no pending redirect, no hazard:
    - fetch_valid=1, pc_stall=0 (increment), go to FETCH.
    - halt in this cycle has no effect; it is handled in FETCH.
- HALTED:
  - imem_req=0, pc_stall=1.
  - halt and hazard_stall are ignored.
  - redirect_valid (an older branch cancels the halt): pc_load=1, pc_target=redirect_target, flush_if=1, flush_id=1, go to FETCH.
  - Otherwise stays in HALTED until reset.
- pc_load and pc_stall are never both 1.
- redirect_count increments on every cycle with pc_load=1 and saturates at 2^CNT_WIDTH-1 (255 by default); it does not wrap.
- Reset asserted mid-WAIT with a redirect pending: the pending redirect is discarded and no pc_load is issued.

Test Plan:
- Reset release, imem_ready=1, no hazards -> cycle 0 in IDLE (pc_stall=1, imem_req=0); then fetch_valid=1 and PC increments every cycle; state_dbg=1.
- In FETCH, redirect_valid=1 with redirect_target=20'h0F1F -> same cycle pc_load=1, pc_target=20'h0F1F, flush_if=flush_id=1; redirect_count=1; next cycle normal fetch.
- imem_ready=0 for 3 cycles; redirect to 20'h00100 in wait cycle 2; imem_ready=1 in cycle 4 -> pc_stall=1 in cycles 1-3, then pc_load=1 with 20'h00100 and fetch_valid=0; pend cleared; state returns to FETCH.
- halt=1 and hazard_stall=1 together in FETCH -> state HALTED with imem_req=0; then redirect_valid to 20'h00040 -> pc_load=1, state FETCH.
- hazard_stall=1 for 2 cycles in FETCH -> pc_stall=1 and fetch_valid=0 for exactly 2 cycles; redirect_valid during the stall -> load wins and pc_stall=0 that cycle.
- 300 consecutive redirects -> redirect_count holds at 255; assert reset=0 mid-WAIT with a pending redirect -> state IDLE, count 0, no pc_load after release.
